// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and its arbiter:
//   - default operand, shift-amount and opcode widths
//   - ALU opcode constants
//   - arbiter state encoding
//   - op_is_legal(): membership test for the supported opcode set
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned BITS_SIZE  = 32;
    localparam int unsigned BITS_SHAMT = 5;
    localparam int unsigned BITS_OP    = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
            ALU_NOR, ALU_XOR, ALU_SLT, ALU_SRL: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant.
//   valid       in  2  request valid per port
//   prio        in  1  port that wins when both are valid
//   grant_valid out 1  at least one port is requesting
//   grant       out 1  index of the winning port (meaningful with grant_valid)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic       grant_valid,
    output logic       grant
);

    always_comb begin
        grant_valid = |valid;
        grant       = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = prio;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational execute-stage ALU between two requesters
// (port 0: pipeline execute stage, port 1: debug/test unit). Requests are
// arbitrated round-robin, the winner's operands are registered onto the ALU
// inputs, the ALU result is captured one cycle later and returned on the
// winner's response handshake. One operation in flight at a time.
//
// Optional build macro: ALU_ARBITER_OP_CHECK_EN
//   When defined, an illegal opcode is accepted but not executed; it gets an
//   immediate response with result/zero = 0 and o_rsp_err = 1.
//
// Ports (port n payload in slice [n*W +: W]):
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   per-port request handshake
//   i_req_a, i_req_b, i_req_shamt, i_req_flag_shamt, i_req_op  request payload
//   o_rsp_valid/i_rsp_ready   per-port response handshake
//   o_rsp_result, o_rsp_zero  captured ALU result/zero (shared)
//   o_rsp_err             illegal-opcode response (only with the macro)
//   o_alu_*               registered ALU operands/opcode
//   i_alu_result, i_alu_zero  ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned BITS_SIZE  = alu_pkg::BITS_SIZE,
    parameter int unsigned BITS_SHAMT = alu_pkg::BITS_SHAMT,
    parameter int unsigned BITS_OP    = alu_pkg::BITS_OP
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [1:0]              i_req_valid,
    output logic [1:0]              o_req_ready,
    input  logic [2*BITS_SIZE-1:0]  i_req_a,
    input  logic [2*BITS_SIZE-1:0]  i_req_b,
    input  logic [2*BITS_SHAMT-1:0] i_req_shamt,
    input  logic [1:0]              i_req_flag_shamt,
    input  logic [2*BITS_OP-1:0]    i_req_op,
    output logic [1:0]              o_rsp_valid,
    input  logic [1:0]              i_rsp_ready,
    output logic [BITS_SIZE-1:0]    o_rsp_result,
    output logic                    o_rsp_zero,
    output logic [BITS_SIZE-1:0]    o_alu_a,
    output logic [BITS_SIZE-1:0]    o_alu_b,
    output logic [BITS_SHAMT-1:0]   o_alu_shamt,
    output logic                    o_alu_flag_shamt,
    output logic [BITS_OP-1:0]      o_alu_op,
    input  logic [BITS_SIZE-1:0]    i_alu_result,
    input  logic                    i_alu_zero
`ifdef ALU_ARBITER_OP_CHECK_EN
    ,
    output logic                    o_rsp_err
`endif
);

    arb_state_t state;
    logic       grant;
    logic       prio;

    logic       arb_valid;
    logic       arb_grant;

    logic [BITS_SIZE-1:0]  win_a;
    logic [BITS_SIZE-1:0]  win_b;
    logic [BITS_SHAMT-1:0] win_shamt;
    logic                  win_flag_shamt;
    logic [BITS_OP-1:0]    win_op;

    rr_arbiter2 u_rr_arbiter2 (
        .valid       (i_req_valid),
        .prio        (prio),
        .grant_valid (arb_valid),
        .grant       (arb_grant)
    );

    // Winner payload mux.
    always_comb begin
        win_a          = arb_grant ? i_req_a[BITS_SIZE +: BITS_SIZE]
                                   : i_req_a[0 +: BITS_SIZE];
        win_b          = arb_grant ? i_req_b[BITS_SIZE +: BITS_SIZE]
                                   : i_req_b[0 +: BITS_SIZE];
        win_shamt      = arb_grant ? i_req_shamt[BITS_SHAMT +: BITS_SHAMT]
                                   : i_req_shamt[0 +: BITS_SHAMT];
        win_flag_shamt = arb_grant ? i_req_flag_shamt[1] : i_req_flag_shamt[0];
        win_op         = arb_grant ? i_req_op[BITS_OP +: BITS_OP]
                                   : i_req_op[0 +: BITS_OP];
    end

    // Ready is only ever offered to the current winner while idle.
    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && arb_valid) begin
            o_req_ready[arb_grant] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            grant            <= 1'b0;
            prio             <= 1'b0;
            o_rsp_valid      <= '0;
            o_rsp_result     <= '0;
            o_rsp_zero       <= 1'b0;
            o_alu_a          <= '0;
            o_alu_b          <= '0;
            o_alu_shamt      <= '0;
            o_alu_flag_shamt <= 1'b0;
            o_alu_op         <= '0;
`ifdef ALU_ARBITER_OP_CHECK_EN
            o_rsp_err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        o_alu_a          <= win_a;
                        o_alu_b          <= win_b;
                        o_alu_shamt      <= win_shamt;
                        o_alu_flag_shamt <= win_flag_shamt;
                        o_alu_op         <= win_op;
                        grant            <= arb_grant;
`ifdef ALU_ARBITER_OP_CHECK_EN
                        if (!op_is_legal(win_op[3:0])) begin
                            // Illegal op: respond immediately, ALU result unused.
                            o_rsp_result           <= '0;
                            o_rsp_zero             <= 1'b0;
                            o_rsp_err              <= 1'b1;
                            o_rsp_valid[arb_grant] <= 1'b1;
                            state                  <= RESP;
                        end else begin
                            state <= EXEC;
                        end
`else
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    o_rsp_result       <= i_alu_result;
                    o_rsp_zero         <= i_alu_zero;
                    o_rsp_valid[grant] <= 1'b1;
`ifdef ALU_ARBITER_OP_CHECK_EN
                    o_rsp_err          <= 1'b0;
`endif
                    state              <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready[grant]) begin
                        o_rsp_valid <= '0;
                        prio        <= ~grant;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_shamt;
    logic [1:0]  req_flag;
    logic [7:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic        alu_flag;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
`ifdef ALU_ARBITER_OP_CHECK_EN
    logic        rsp_err;
`endif

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.BITS_SIZE(32), .BITS_SHAMT(5), .BITS_OP(4)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_a          (req_a),
        .i_req_b          (req_b),
        .i_req_shamt      (req_shamt),
        .i_req_flag_shamt (req_flag),
        .i_req_op         (req_op),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_result     (rsp_result),
        .o_rsp_zero       (rsp_zero),
        .o_alu_a          (alu_a),
        .o_alu_b          (alu_b),
        .o_alu_shamt      (alu_shamt),
        .o_alu_flag_shamt (alu_flag),
        .o_alu_op         (alu_op),
        .i_alu_result     (alu_result),
        .i_alu_zero       (alu_zero)
`ifdef ALU_ARBITER_OP_CHECK_EN
        ,
        .o_rsp_err        (rsp_err)
`endif
    );

    // Behavioural ALU: used both as the external ALU and as the reference.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] shamt, input logic flag,
                                            input logic [3:0] op);
        logic [4:0] sh;
        sh = flag ? shamt : b[4:0];
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOR: return ~(a | b);
            ALU_XOR: return a ^ b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SRL: return a >> sh;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_a, alu_b, alu_shamt, alu_flag, alu_op);
        alu_zero   = (alu_result == 32'd0);
    end

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, input logic fl, input logic [3:0] op);
        req_a[p*32 +: 32]   = a;
        req_b[p*32 +: 32]   = b;
        req_shamt[p*5 +: 5] = sh;
        req_flag[p]         = fl;
        req_op[p*4 +: 4]    = op;
        req_valid[p]        = 1'b1;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = '0;
        i_rst_n   = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({alu_a, alu_b, alu_shamt, alu_flag, alu_op} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got a=%0h b=%0h sh=%0h f=%0b op=%0h expected all 0",
                     alu_a, alu_b, alu_shamt, alu_flag, alu_op);
        end
        checks++;
        if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b result=%0h zero=%b ready=%b expected 0",
                     rsp_valid, rsp_result, rsp_zero, req_ready);
        end
    endtask

    task automatic test_tie();
        drive_req(0, 32'd3, 32'd1, 5'd0, 1'b0, ALU_AND);
        drive_req(1, 32'd2, 32'd1, 5'd0, 1'b0, ALU_OR);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL tie_first_grant: got %b expected 01", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL tie_busy_ready: got %b expected 00", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd1) begin
            errors++; $display("FAIL tie_rsp0: got valid=%b result=%0h expected 01/1", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        checks++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL tie_second_grant: got ready=%b valid=%b expected 10/00", req_ready, rsp_valid);
        end
        tick();
        req_valid[1] = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'd3) begin
            errors++; $display("FAIL tie_rsp1: got valid=%b result=%0h expected 10/3", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        drive_req(0, 32'd7, 32'd7, 5'd0, 1'b0, ALU_XOR);
        drive_req(1, 32'd7, 32'd7, 5'd0, 1'b0, ALU_XOR);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL tie_next_round: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_port0();
        drive_req(0, 32'd2, 32'd1, 5'd0, 1'b0, ALU_ADD);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL p0_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        checks++;
        if (alu_a !== 32'd2 || alu_b !== 32'd1 || alu_op !== ALU_ADD || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL p0_latch: got a=%0h b=%0h op=%0h valid=%b expected 2/1/0/00",
                               alu_a, alu_b, alu_op, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd3 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL p0_rsp: got valid=%b result=%0h zero=%b expected 01/3/0",
                               rsp_valid, rsp_result, rsp_zero);
        end
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL p0_rsp_done: got %b expected 00", rsp_valid);
        end
    endtask

    task automatic test_port1();
        drive_req(1, 32'd1, 32'd1, 5'd0, 1'b0, ALU_SUB);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL p1_ready: got %b expected 10", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
            errors++; $display("FAIL p1_rsp: got valid=%b result=%0h zero=%b expected 10/0/1",
                               rsp_valid, rsp_result, rsp_zero);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        drive_req(0, 32'd5, 32'd3, 5'd0, 1'b0, ALU_XOR);
        tick();
        req_valid[0] = 1'b0;
        drive_req(1, 32'd9, 32'd4, 5'd0, 1'b0, ALU_SUB);
        tick();
        rsp_ready = 2'b10;  // non-granted port's accept must be ignored
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'd6 || req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid=%b result=%0h ready=%b expected 01/6/00",
                                   i, rsp_valid, rsp_result, req_ready);
            end
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 00/10", rsp_valid, req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_result !== 32'd5) begin
            errors++; $display("FAIL bp_p1_rsp: got valid=%b result=%0h expected 10/5", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_shift();
        drive_req(0, 32'h8000_0000, 32'd0, 5'd31, 1'b1, ALU_SRL);
        tick();
        req_valid[0] = 1'b0;
        checks++;
        if (alu_shamt !== 5'd31 || alu_flag !== 1'b1 || alu_op !== ALU_SRL) begin
            errors++; $display("FAIL shift_latch: got sh=%0d f=%b op=%0h expected 31/1/9", alu_shamt, alu_flag, alu_op);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result !== 32'd1) begin
            errors++; $display("FAIL shift_rsp: got valid=%b result=%0h expected 01/1", rsp_valid, rsp_result);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_exec();
        drive_req(1, 32'h1234, 32'h1, 5'd0, 1'b0, ALU_ADD);
        tick();
        req_valid = 2'b00;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_shamt, alu_flag, alu_op} !== '0 || rsp_valid !== 2'b00 ||
            rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL rst_exec_async: got a=%0h valid=%b result=%0h expected 0",
                               alu_a, rsp_valid, rsp_result);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rst_exec_norsp: got valid=%b ready=%b expected 00/00", rsp_valid, req_ready);
        end
    endtask

`ifdef ALU_ARBITER_OP_CHECK_EN
    task automatic test_op_check();
        drive_req(0, 32'd5, 32'd5, 5'd0, 1'b0, 4'b1111);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL opchk_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL opchk_illegal: got valid=%b err=%b result=%0h zero=%b expected 01/1/0/0",
                               rsp_valid, rsp_err, rsp_result, rsp_zero);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        drive_req(0, 32'd2, 32'd1, 5'd0, 1'b0, ALU_ADD);
        tick();
        req_valid[0] = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_result !== 32'd3) begin
            errors++; $display("FAIL opchk_legal: got valid=%b err=%b result=%0h expected 01/0/3",
                               rsp_valid, rsp_err, rsp_result);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask
`endif

    // Transaction-level model: one op outstanding, response visible two
    // edges after acceptance, tie goes to the port not served last.
    task automatic test_random();
        logic [3:0]  legal_ops [8];
        bit          busy;
        int          wait_edges;
        int          mport;
        bit          mprio;
        logic [31:0] mres;
        int          win;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rv;
        legal_ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLT, ALU_SRL};
        apply_reset();
        busy = 0; wait_edges = 0; mport = 0; mprio = 0; mres = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
                    drive_req(p, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                              legal_ops[$urandom_range(0, 7)]);
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            win = -1;
            if (!busy) begin
                if (req_valid == 2'b01)      win = 0;
                else if (req_valid == 2'b10) win = 1;
                else if (req_valid == 2'b11) win = int'(mprio);
            end
            exp_rdy = (win >= 0) ? 2'(1 << win) : 2'b00;
            exp_rv  = (busy && wait_edges == 0) ? 2'(1 << mport) : 2'b00;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_rdy);
            end
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", cyc, rsp_valid, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rsp_result !== mres || rsp_zero !== (mres == 32'd0)) begin
                    errors++; $display("FAIL rand_result[%0d]: got %0h/%b expected %0h/%b",
                                       cyc, rsp_result, rsp_zero, mres, (mres == 32'd0));
                end
            end
            if (busy) begin
                if (wait_edges > 0) wait_edges--;
                else if (rsp_ready[mport]) begin
                    busy  = 0;
                    mprio = (mport == 0);
                end
            end
            if (win >= 0) begin
                busy       = 1;
                wait_edges = 1;
                mport      = win;
                mres       = ref_alu(req_a[win*32 +: 32], req_b[win*32 +: 32], req_shamt[win*5 +: 5],
                                     req_flag[win], req_op[win*4 +: 4]);
            end
            tick();
            if (win >= 0) req_valid[win] = 1'b0;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        tick(); tick(); tick();
        rsp_ready = 2'b00;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_shamt = '0;
        req_flag  = '0;
        req_op    = '0;
        rsp_ready = '0;
        test_reset();
        test_tie();
        test_port0();
        test_port1();
        test_backpressure();
        test_shift();
        test_reset_exec();
`ifdef ALU_ARBITER_OP_CHECK_EN
        test_op_check();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
